exc_sched: RTL and testbench
============================

EXC_SCHED -- requirements
Module: exc_sched

Interface
REQ-001 Parameter DRAIN_CYCLES, default 2, pipeline-flush stall length after exception/eret issue (1..7).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 instr_valid  input  1  retiring instruction valid this cycle; qualifies syscall/brk/teq/eret_in/pc.
REQ-005 pc  input  32  address of retiring instruction.
REQ-006 syscall, brk, teq  input  1 each  synchronous exception flags of retiring instruction.
REQ-007 eret_in  input  1  retiring instruction is eret.
REQ-008 irq  input  4  level external interrupt lines.
REQ-009 status  input  32  live CP0 Status register value.
REQ-010 exception  output  1  one-cycle pulse to CP0: take exception.
REQ-011 cause  output  5  exception code to CP0, valid with exception.
REQ-012 epc  output  32  PC to save, valid with exception.
REQ-013 eret  output  1  one-cycle pulse to CP0: return.
REQ-014 stall  output  1  freeze fetch/retire.
REQ-015 redirect  output  1  one-cycle pulse: load PC from CP0 exc_addr.

Function
REQ-016 Enables: status[0] global IE; syscall/brk/teq gated by status[8]/[9]/[10]; irq[i] gated by status[11+i]; disabled requests ignored, not queued.
REQ-017 Cause codes: syscall 5'h08, brk 5'h09, teq 5'h0D, interrupt 5'h00.
REQ-018 Priority when several enabled in one cycle: teq > brk > syscall > irq[3] > ... > irq[0].
REQ-019 irq_pend[3:0]: bit sets on rising edge of enabled irq[i]; cleared only when that interrupt is taken; cleared if its enable drops.
REQ-020 FSM states IDLE, EXC, RET, DRAIN; state held in a registered encoding.
REQ-021 IDLE: synchronous exception with instr_valid -> EXC, epc<=pc; else eret_in with instr_valid -> RET; else any irq_pend with status[0] -> EXC, epc<=pc of next valid retire (interrupt taken only on an instr_valid cycle).
REQ-022 EXC: exception=1, cause/epc driven from registers, exactly one cycle, -> DRAIN.
REQ-023 RET: eret=1 exactly one cycle, -> DRAIN.
REQ-024 DRAIN: 3-bit counter from DRAIN_CYCLES down to 1; redirect=1 in final DRAIN cycle; -> IDLE.
REQ-025 stall=1 in EXC, RET, DRAIN and in the IDLE cycle a transition is decided; 0 otherwise.
REQ-026 Requests arriving while not IDLE ignored (pipeline frozen); irq edges still recorded in irq_pend.
REQ-027 eret_in and pending irq same cycle: eret taken; irq taken after return to IDLE.
REQ-028 Synchronous exception flag plus eret_in on same instruction: exception taken, eret dropped.
REQ-029 exception and eret never asserted in the same cycle.

Reset
REQ-030 rst_n low: state IDLE, counter 0, irq_pend 0, epc/cause registers 0, all outputs 0, immediately (asynchronous).
REQ-031 Reset asserted mid-EXC/RET/DRAIN aborts sequence; no redirect issued.
REQ-032 Reset deassertion takes effect on next rising clk edge.

Structure
REQ-033 Shared package holds cause codes, Status bit indices (IE, 8/9/10, irq base 11), FSM state encoding; cp0 uses the same constants.
REQ-034 One sub-module, exc_prio_enc: combinational enable-gating plus priority encoder producing req_any, cause.

Verification
REQ-035 status=0x0000_0101, instr_valid, syscall, pc=0x0040_0020 -> next cycle exception=1, cause=0x08, epc=0x0040_0020; redirect on cycle 1+DRAIN_CYCLES.
REQ-036 status=0x0000_0701, teq+brk same cycle -> cause=0x0D only, single exception pulse.
REQ-037 status=0x0000_0001 (brk disabled), brk -> no exception, stall=0.
REQ-038 status=0x0000_1001, irq[1] rising then instr_valid pc=0x0040_0100 -> cause=0x00, epc=0x0040_0100, irq_pend[1] cleared.
REQ-039 eret_in and pending irq[0] same cycle -> eret pulse, DRAIN, IDLE, then exception cause=0x00.
REQ-040 rst_n low during DRAIN -> all outputs 0 immediately, no redirect, state IDLE after release.

Source files
------------

// File: rtl/exc_sched_pkg.sv
// ----------------------------------------------------------------------------
// exc_sched_pkg
// Constants shared by the exception scheduler and the CP0 register block:
// exception cause codes, Status register bit positions and the scheduler
// FSM state encoding.
// ----------------------------------------------------------------------------
package exc_sched_pkg;

  // Exception codes written to CP0 Cause.ExcCode
  localparam logic [4:0] CAUSE_INT = 5'h00;
  localparam logic [4:0] CAUSE_SYS = 5'h08;
  localparam logic [4:0] CAUSE_BP  = 5'h09;
  localparam logic [4:0] CAUSE_TR  = 5'h0D;

  // Status register bit positions
  localparam int ST_IE       = 0;
  localparam int ST_SYS_EN   = 8;
  localparam int ST_BRK_EN   = 9;
  localparam int ST_TEQ_EN   = 10;
  localparam int ST_IRQ_BASE = 11;
  localparam int NUM_IRQ     = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXC   = 2'd1,
    S_RET   = 2'd2,
    S_DRAIN = 2'd3
  } exc_state_e;

  // Per-line interrupt enables extracted from Status
  function automatic logic [NUM_IRQ-1:0] irq_enables(input logic [31:0] status);
    return status[ST_IRQ_BASE +: NUM_IRQ];
  endfunction

  // Synchronous exception enables, ordered {teq, brk, syscall}
  function automatic logic [2:0] sync_enables(input logic [31:0] status);
    return {status[ST_TEQ_EN], status[ST_BRK_EN], status[ST_SYS_EN]};
  endfunction

endpackage

// File: rtl/exc_sched_prio.sv
// ----------------------------------------------------------------------------
// exc_prio_enc
// Combinational enable gating and fixed-priority selection of the request
// to service. Priority: teq > brk > syscall > irq[3] > irq[2] > irq[1] > irq[0].
//
// Ports
//   instr_valid_i   retiring instruction valid (qualifies every request)
//   syscall_i       syscall flag of retiring instruction
//   brk_i           break flag of retiring instruction
//   teq_i           trap flag of retiring instruction
//   sync_en_i[2:0]  enables {teq, brk, syscall}
//   ie_i            global interrupt enable
//   irq_en_i[3:0]   per-line interrupt enables
//   irq_pend_i[3:0] recorded interrupt requests
//   sync_req_o      an enabled synchronous exception is present
//   irq_req_o       an enabled pending interrupt can be taken this cycle
//   req_any_o       sync_req_o | irq_req_o
//   cause_o[4:0]    cause code of the winning request
//   irq_take_o[3:0] one-hot of the highest-priority takeable interrupt
// ----------------------------------------------------------------------------
module exc_prio_enc
  import exc_sched_pkg::*;
(
  input  logic               instr_valid_i,
  input  logic               syscall_i,
  input  logic               brk_i,
  input  logic               teq_i,
  input  logic [2:0]         sync_en_i,
  input  logic               ie_i,
  input  logic [NUM_IRQ-1:0] irq_en_i,
  input  logic [NUM_IRQ-1:0] irq_pend_i,
  output logic               sync_req_o,
  output logic               irq_req_o,
  output logic               req_any_o,
  output logic [4:0]         cause_o,
  output logic [NUM_IRQ-1:0] irq_take_o
);

  logic [2:0]         sync_vec;
  logic [NUM_IRQ-1:0] irq_vec;

  // Interrupts are only accepted on a retiring instruction so that the
  // saved EPC always names a real instruction.
  assign sync_vec   = {teq_i, brk_i, syscall_i} & sync_en_i & {3{instr_valid_i}};
  assign irq_vec    = irq_pend_i & irq_en_i & {NUM_IRQ{ie_i & instr_valid_i}};
  assign sync_req_o = |sync_vec;
  assign irq_req_o  = |irq_vec;
  assign req_any_o  = sync_req_o | irq_req_o;

  always_comb begin
    irq_take_o = '0;
    // Ascending scan so the highest-numbered line wins.
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (irq_vec[i]) begin
        irq_take_o    = '0;
        irq_take_o[i] = 1'b1;
      end
    end
  end

  always_comb begin
    cause_o = CAUSE_INT;
    if (sync_vec[2]) begin
      cause_o = CAUSE_TR;
    end else if (sync_vec[1]) begin
      cause_o = CAUSE_BP;
    end else if (sync_vec[0]) begin
      cause_o = CAUSE_SYS;
    end
  end

endmodule

// File: rtl/exc_sched.sv
// ----------------------------------------------------------------------------
// exc_sched
// Exception / interrupt / eret scheduler. Decides at instruction retire
// whether to take an exception or return, pulses CP0, then holds the pipeline
// frozen for DRAIN_CYCLES before requesting a PC redirect.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | normal retire; decision made combinationally on retire
// EXC   | one-cycle exception pulse to CP0 with cause/epc
// RET   | one-cycle eret pulse to CP0
// DRAIN | pipeline flush; counts DRAIN_CYCLES..1, redirect on the last
//
// Ports
//   clk, rst_n       clock, async active-low reset
//   instr_valid      retiring instruction valid
//   pc[31:0]         retiring instruction address
//   syscall/brk/teq  synchronous exception flags
//   eret_in          retiring instruction is eret
//   irq[3:0]         level interrupt lines
//   status[31:0]     live CP0 Status
//   exception        pulse: take exception
//   cause[4:0]       exception code, valid with exception
//   epc[31:0]        PC to save, valid with exception
//   eret             pulse: return from exception
//   stall            freeze fetch/retire
//   redirect         pulse: load PC from CP0 exc_addr
// ----------------------------------------------------------------------------
module exc_sched
  import exc_sched_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] pc,
  input  logic        syscall,
  input  logic        brk,
  input  logic        teq,
  input  logic        eret_in,
  input  logic [3:0]  irq,
  input  logic [31:0] status,
  output logic        exception,
  output logic [4:0]  cause,
  output logic [31:0] epc,
  output logic        eret,
  output logic        stall,
  output logic        redirect
);

  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES);

  exc_state_e         state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] irq_pend_q, irq_pend_d;
  logic [31:0]        epc_q, epc_d;
  logic [4:0]         cause_q, cause_d;

  logic               sync_req;
  logic               irq_req;
  logic               req_any;
  logic [4:0]         enc_cause;
  logic [NUM_IRQ-1:0] irq_take;
  logic [NUM_IRQ-1:0] irq_clr;
  logic [NUM_IRQ-1:0] irq_en;
  logic [NUM_IRQ-1:0] irq_rise;
  logic               status_unused;

  assign status_unused = ^{status[31:ST_IRQ_BASE+NUM_IRQ], status[ST_SYS_EN-1:1]};

  assign irq_en   = irq_enables(status);
  assign irq_rise = irq & ~irq_q;

  exc_prio_enc u_prio (
    .instr_valid_i (instr_valid),
    .syscall_i     (syscall),
    .brk_i         (brk),
    .teq_i         (teq),
    .sync_en_i     (sync_enables(status)),
    .ie_i          (status[ST_IE]),
    .irq_en_i      (irq_en),
    .irq_pend_i    (irq_pend_q),
    .sync_req_o    (sync_req),
    .irq_req_o     (irq_req),
    .req_any_o     (req_any),
    .cause_o       (enc_cause),
    .irq_take_o    (irq_take)
  );

  // A new edge re-arms a line even if that line is being taken this cycle;
  // losing the enable discards the request outright.
  assign irq_pend_d = ((irq_pend_q & ~irq_clr) | irq_rise) & irq_en;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    epc_d     = epc_q;
    cause_d   = cause_q;
    irq_clr   = '0;
    exception = 1'b0;
    eret      = 1'b0;
    stall     = 1'b0;
    redirect  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Decisions are gated by rst_n so the Mealy stall stays low while
        // reset is held, whatever the retire inputs do.
        if (rst_n) begin
          if (sync_req) begin
            state_d = S_EXC;
            epc_d   = pc;
            cause_d = enc_cause;
            stall   = 1'b1;
          end else if (instr_valid && eret_in) begin
            state_d = S_RET;
            stall   = 1'b1;
          end else if (req_any) begin
            state_d = S_EXC;
            epc_d   = pc;
            cause_d = enc_cause;
            irq_clr = irq_take;
            stall   = 1'b1;
          end
        end
      end
      S_EXC: begin
        exception = 1'b1;
        stall     = 1'b1;
        cnt_d     = DRAIN_LOAD;
        state_d   = S_DRAIN;
      end
      S_RET: begin
        eret    = 1'b1;
        stall   = 1'b1;
        cnt_d   = DRAIN_LOAD;
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        stall = 1'b1;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          redirect = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      irq_q      <= '0;
      irq_pend_q <= '0;
      epc_q      <= '0;
      cause_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      irq_q      <= irq;
      irq_pend_q <= irq_pend_d;
      epc_q      <= epc_d;
      cause_q    <= cause_d;
    end
  end

  assign cause = cause_q;
  assign epc   = epc_q;

endmodule

// File: tb/tb_exc_sched.sv
module tb_exc_sched;

  localparam int D = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] pc = '0;
  logic        syscall = 1'b0, brk = 1'b0, teq = 1'b0, eret_in = 1'b0;
  logic [3:0]  irq = '0;
  logic [31:0] status = '0;
  logic        exception, eret, stall, redirect;
  logic [4:0]  cause;
  logic [31:0] epc;

  // values applied at the next falling edge
  logic        rst_lvl = 1'b0;
  logic [31:0] st_lvl = '0;
  logic [3:0]  irq_lvl = '0;

  int checks = 0;
  int failures = 0;

  // reference model: ph = -1 when free, else cycles since the decision
  int          ph = -1;
  bit          m_is_exc;
  logic [4:0]  m_cause;
  logic [31:0] m_epc;
  logic [3:0]  m_pend = '0;
  logic [3:0]  m_prev = '0;

  exc_sched #(.DRAIN_CYCLES(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_valid(instr_valid),
    .pc         (pc),
    .syscall    (syscall),
    .brk        (brk),
    .teq        (teq),
    .eret_in    (eret_in),
    .irq        (irq),
    .status     (status),
    .exception  (exception),
    .cause      (cause),
    .epc        (epc),
    .eret       (eret),
    .stall      (stall),
    .redirect   (redirect)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic iv, input logic [31:0] p, input logic sc,
                       input logic bk, input logic tq, input logic er);
    logic e_exc, e_eret, e_stall, e_redir;
    logic s_sc, s_bk, s_tq;
    logic [3:0] en, take;
    int nph, hi;
    @(negedge clk);
    rst_n = rst_lvl; status = st_lvl; irq = irq_lvl;
    instr_valid = iv; pc = p; syscall = sc; brk = bk; teq = tq; eret_in = er;
    #1;
    e_exc = 0; e_eret = 0; e_stall = 0; e_redir = 0; take = '0; nph = -1; hi = 0;
    en = status[14:11];
    if (!rst_n) begin
      ph = -1; m_pend = '0; m_prev = '0;
      chk("rst_exception", exception, 0);
      chk("rst_eret", eret, 0);
      chk("rst_stall", stall, 0);
      chk("rst_redirect", redirect, 0);
      chk("rst_cause", cause, 0);
      chk("rst_epc", epc, 0);
    end else begin
      if (ph < 0) begin
        s_sc = iv && sc && status[8];
        s_bk = iv && bk && status[9];
        s_tq = iv && tq && status[10];
        if (s_sc || s_bk || s_tq) begin
          m_is_exc = 1; m_epc = p;
          m_cause = s_tq ? 5'h0D : (s_bk ? 5'h09 : 5'h08);
          e_stall = 1; nph = 1;
        end else if (iv && er) begin
          m_is_exc = 0; e_stall = 1; nph = 1;
        end else if (iv && status[0] && ((m_pend & en) != 0)) begin
          for (int i = 0; i < 4; i++) if (m_pend[i] && en[i]) hi = i;
          take[hi] = 1'b1;
          m_is_exc = 1; m_epc = p; m_cause = 5'h00;
          e_stall = 1; nph = 1;
        end
      end else begin
        e_stall = 1;
        if (ph == 1) begin
          e_exc = m_is_exc; e_eret = !m_is_exc;
        end
        if (ph == 1 + D) e_redir = 1;
        nph = (ph == 1 + D) ? -1 : ph + 1;
      end
      chk("exception", exception, e_exc);
      chk("eret", eret, e_eret);
      chk("stall", stall, e_stall);
      chk("redirect", redirect, e_redir);
      if (e_exc) begin
        chk("cause", cause, m_cause);
        chk("epc", epc, m_epc);
      end
      ph = nph;
      for (int i = 0; i < 4; i++) begin
        if (!en[i]) m_pend[i] = 1'b0;
        else if (irq[i] && !m_prev[i]) m_pend[i] = 1'b1;
        else if (take[i]) m_pend[i] = 1'b0;
      end
      m_prev = irq;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 32'h0, 0, 0, 0, 0);
  endtask

  initial begin
    // reset with busy inputs: nothing may leak out
    rst_lvl = 0; st_lvl = 32'h0000_0701;
    cycle(1, 32'h1234, 1, 1, 1, 1);
    cycle(1, 32'h1234, 1, 0, 0, 0);
    rst_lvl = 1; st_lvl = 32'h0;
    idle(2);

    // syscall: pulse next cycle, redirect on cycle 1+D
    st_lvl = 32'h0000_0101;
    cycle(1, 32'h0040_0020, 1, 0, 0, 0);
    chk("sys_decide_stall", stall, 1);
    cycle(0, 32'h0, 0, 0, 0, 0);
    chk("sys_exception", exception, 1);
    chk("sys_cause", cause, 5'h08);
    chk("sys_epc", epc, 32'h0040_0020);
    for (int k = 1; k <= D; k++) begin
      cycle(0, 32'h0, 0, 0, 0, 0);
      if (k == D) chk("sys_redirect_last", redirect, 1);
    end
    idle(1);
    chk("sys_back_idle_stall", stall, 0);

    // teq + brk together: teq wins, single pulse
    st_lvl = 32'h0000_0701;
    cycle(1, 32'h0040_0040, 0, 1, 1, 0);
    cycle(0, 32'h0, 0, 0, 0, 0);
    chk("teq_cause", cause, 5'h0D);
    cycle(0, 32'h0, 0, 0, 0, 0);
    chk("teq_single_pulse", exception, 0);
    idle(D);

    // brk disabled: ignored
    st_lvl = 32'h0000_0001;
    cycle(1, 32'h0040_0060, 0, 1, 0, 0);
    chk("brk_dis_stall", stall, 0);
    cycle(0, 32'h0, 0, 0, 0, 0);
    chk("brk_dis_exception", exception, 0);

    // syscall + eret on one instruction: exception, not eret
    st_lvl = 32'h0000_0101;
    cycle(1, 32'h0040_0080, 1, 0, 0, 1);
    cycle(0, 32'h0, 0, 0, 0, 0);
    chk("sys_eret_exc", exception, 1);
    chk("sys_eret_no_eret", eret, 0);
    idle(D);

    // irq[1] edge, then taken on next retire
    st_lvl = 32'h0000_1001; irq_lvl = 4'b0010;
    idle(1);
    cycle(1, 32'h0040_0100, 0, 0, 0, 0);
    chk("irq1_decide_stall", stall, 1);
    cycle(0, 32'h0, 0, 0, 0, 0);
    chk("irq1_cause", cause, 5'h00);
    chk("irq1_epc", epc, 32'h0040_0100);
    chk("irq1_pend_clr", dut.irq_pend_q[1], 0);
    irq_lvl = 4'b0000;
    idle(D + 1);

    // eret and pending irq[0]: eret first, interrupt after
    st_lvl = 32'h0000_0801; irq_lvl = 4'b0001;
    idle(1);
    cycle(1, 32'h0040_0200, 0, 0, 0, 1);
    cycle(0, 32'h0, 0, 0, 0, 0);
    chk("eret_irq_eret", eret, 1);
    chk("eret_irq_noexc", exception, 0);
    idle(D);
    cycle(1, 32'h0040_0300, 0, 0, 0, 0);
    chk("eret_irq_decide", stall, 1);
    cycle(0, 32'h0, 0, 0, 0, 0);
    chk("eret_irq_exc", exception, 1);
    chk("eret_irq_cause", cause, 5'h00);
    chk("eret_irq_epc", epc, 32'h0040_0300);
    irq_lvl = 4'b0000;
    idle(D + 1);

    // reset asserted mid-DRAIN
    st_lvl = 32'h0000_0101;
    cycle(1, 32'h0040_0400, 1, 0, 0, 0);
    cycle(0, 32'h0, 0, 0, 0, 0);
    cycle(0, 32'h0, 0, 0, 0, 0);
    #2 rst_n = 1'b0; rst_lvl = 0;
    #1;
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_redirect", redirect, 0);
    chk("mid_rst_exception", exception, 0);
    chk("mid_rst_cause", cause, 0);
    chk("mid_rst_epc", epc, 0);
    for (int k = 0; k < D + 2; k++) cycle(1, 32'h0040_0500, 1, 0, 0, 0);
    rst_lvl = 1;
    idle(1);
    cycle(1, 32'h0040_0600, 1, 0, 0, 0);
    chk("post_rst_accept", stall, 1);
    idle(D + 2);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        st_lvl = $urandom;
        st_lvl[0] = ($urandom_range(0, 3) != 0);
        st_lvl[10:8] = 3'($urandom | $urandom);
        st_lvl[14:11] = 4'($urandom | $urandom);
      end
      if ($urandom_range(0, 5) == 0) irq_lvl = irq_lvl ^ (4'(1) << $urandom_range(0, 3));
      rst_lvl = ($urandom_range(0, 399) != 0);
      cycle($urandom_range(0, 9) < 7, $urandom,
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
    end
    rst_lvl = 1;
    idle(D + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
